imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It extracts and sign- or zero-extends immediates for all RV32I/RV64I formats (I, S, B, J, U, shift-amount, CSR zimm). It also computes the PC-relative target (pc + imm). Results are registered behind a valid/ready handshake with a two-entry skid buffer, so back-pressure from execute never creates a combinational path to fetch.

## Interface
- XLEN, default 32: datapath width; legal values 32 and 64.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all valid state.
- flush  input  1  synchronous squash of all buffered entries.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  block can accept; registered, not a function of out_ready.
- in_instr  input  32  raw instruction word.
- in_pc  input  XLEN  instruction address.
- in_imm_src  input  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 shamt, 110 zimm, 111 reserved.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  extended immediate.
- out_target  output  XLEN  in_pc + out_imm, modulo 2^XLEN.
- out_illegal  output  1  imm_src was 111; out_imm and out_target are 0.

## Operation
- Extension rules (s = instr[31], replicated to XLEN):
  - I: s, instr[31:20].
  - S: s, instr[31:25], instr[11:7].
  - B: s, instr[7], instr[30:25], instr[11:8], 0.
  - J: s, instr[19:12], instr[20], instr[30:21], 0.
  - U: s-extended instr[31:12], followed by 12 zeros. Bits above 31 are s when XLEN=64.
  - shamt: zero-extended instr[24:20] when XLEN=32; instr[25:20] when XLEN=64.
  - zimm: zero-extended instr[19:15].
  - 111: imm 0, target 0, illegal 1.
- Target is always computed, including for non-PC-relative formats. Consumers ignore it where irrelevant. The add wraps with no overflow flag.
- Storage: main register (drives outputs) plus one skid register. Each holds imm, target and illegal, with a valid bit.
- Accept occurs when in_valid && in_ready. Where accepted data goes:
  - Into main if main is empty, or main is being consumed this cycle and skid is empty.
  - Otherwise into skid.
- When main is consumed (out_valid && out_ready) and skid is valid, skid moves to main in the same edge. A simultaneous accept then lands in skid.
- in_ready = !skid_valid, registered.
- flush clears main_valid and skid_valid at the next edge.
  - flush has priority over a same-cycle accept. Upstream sees the handshake complete, but the data is discarded.
  - A same-cycle out handshake still counts as consumed.
- Reset values: out_valid 0, in_ready 1, out_imm 0, out_target 0, out_illegal 0. The skid payload is don't-care.
- reset asserted mid-transfer drops everything immediately (asynchronous). There is no partial state after release.

## Timing
- Latency: 1 cycle from accept to out_valid when main is empty.
- Throughput: 1 per cycle while out_ready is held high.
- Output payload is stable while out_valid && !out_ready. The payload never changes until a handshake or flush occurs.
- After a stall with skid full, in_ready returns high one cycle after the first out handshake.
- No combinational path from out_ready to in_ready, or from in_* to out_*.
- Extension and add logic sits before the capture registers; the critical path is 32/64-bit add plus mux.

## Test plan
- Formats, XLEN=32, pc=0x00001000, out_ready=1:
  - I: 0xFFF00093 -> imm 0xFFFFFFFF, target 0x00000FFF.
  - S: 0xFE20AE23 -> imm 0xFFFFFFFC.
  - B: 0xFE000CE3 -> imm 0xFFFFFFF8, target 0x00000FF8.
  - J: 0x001000EF -> imm 0x00000800, target 0x00001800.
  - U: 0x123452B7 -> imm 0x12345000.
  - All outputs appear exactly 1 cycle after accept.
- XLEN=64: U 0x800002B7 -> imm 0xFFFFFFFF80000000. shamt with instr[25:20]=6'h3F -> imm 0x3F. Src 111 -> illegal=1, imm=0, target=0.
- Back-pressure: stream 4 back-to-back instructions with out_ready=0.
  - First fills main, second fills skid, in_ready drops the cycle after.
  - Then raise out_ready: all 4 emerge in order, none lost or duplicated, and in_ready recovers after the first drain.
- Simultaneous events: with main full and skid empty, assert an out handshake and an in accept in the same cycle. New data goes to main, skid stays empty, out_valid stays 1.
- Flush with both entries full and in_valid=1: next cycle out_valid=0 and in_ready=1. The flushed data never appears on the output.
- Assert async reset mid-stream, between clock edges: out_valid falls without waiting for an edge, and in_ready=1. The first post-reset accept appears after 1 cycle.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator for RV32I/RV64I.
// Extracts and extends the immediate selected by in_imm_src and computes
// pc + imm. The results are registered behind a valid/ready handshake with
// a main register plus one skid register, so in_ready never depends
// combinationally on out_ready.
//
// Ports:
//   clk, reset (async, active-high), flush (sync squash of buffered entries)
//   in_valid/in_ready, in_instr[31:0], in_pc[XLEN-1:0], in_imm_src[2:0]
//   out_valid/out_ready, out_imm[XLEN-1:0], out_target[XLEN-1:0], out_illegal
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [2:0]      in_imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam logic [2:0] SRC_I     = 3'b000;
  localparam logic [2:0] SRC_S     = 3'b001;
  localparam logic [2:0] SRC_B     = 3'b010;
  localparam logic [2:0] SRC_J     = 3'b011;
  localparam logic [2:0] SRC_U     = 3'b100;
  localparam logic [2:0] SRC_SHAMT = 3'b101;
  localparam logic [2:0] SRC_ZIMM  = 3'b110;

  // Every format is first assembled as a signed 32-bit value; the zero-
  // extended formats keep bit 31 clear, so one sign-extending cast to XLEN
  // handles all of them (including the U-format upper bits on RV64).
  function automatic logic signed [XLEN-1:0] ext_imm(input logic [31:0] instr,
                                                      input logic [2:0]  src);
    logic signed [31:0] v;
    logic [6:0]         unused_opc;
    logic               s;
    unused_opc = instr[6:0];
    s = instr[31];
    v = '0;
    case (src)
      SRC_I:     v = {{20{s}}, instr[31:20]};
      SRC_S:     v = {{20{s}}, instr[31:25], instr[11:7]};
      SRC_B:     v = {{20{s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      SRC_J:     v = {{12{s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      SRC_U:     v = {instr[31:12], 12'b0};
      SRC_SHAMT: v = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
      SRC_ZIMM:  v = {27'b0, instr[19:15]};
      default:   v = '0;
    endcase
    return XLEN'(v);
  endfunction

  // ---- stage p0: combinational extension and target add ----
  logic signed [XLEN-1:0] imm_p0;
  logic        [XLEN-1:0] tgt_p0;
  logic                   ill_p0;

  always_comb begin
    ill_p0 = (in_imm_src == 3'b111);
    imm_p0 = ext_imm(in_instr, in_imm_src);
    tgt_p0 = ill_p0 ? '0 : (in_pc + $unsigned(imm_p0));
  end

  // ---- stage p1: main output register plus skid register ----
  logic                   vld_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic        [XLEN-1:0] tgt_p1;
  logic                   ill_p1;

  logic                   skid_vld;
  logic signed [XLEN-1:0] skid_imm;
  logic        [XLEN-1:0] skid_tgt;
  logic                   skid_ill;

  logic acc;
  logic cons;
  logic main_free;
  logic load_main;
  logic load_skid;
  logic move_skid;

  always_comb begin
    acc       = in_valid && in_ready;
    cons      = vld_p1 && out_ready;
    main_free = !vld_p1 || cons;
    // A freed main slot is refilled from skid first to keep order; the new
    // word then lands in skid. Flush discards everything regardless.
    move_skid = main_free && skid_vld;
    load_main = main_free && !skid_vld && acc;
    load_skid = acc && (!main_free || skid_vld);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      skid_vld <= 1'b0;
    end else if (flush) begin
      vld_p1   <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      if (main_free) vld_p1 <= move_skid || load_main;
      if (move_skid) skid_vld <= load_skid;
      else if (load_skid) skid_vld <= 1'b1;
    end
  end

  // Main payload is reset so the outputs read zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imm_p1 <= '0;
      tgt_p1 <= '0;
      ill_p1 <= 1'b0;
    end else if (!flush) begin
      if (move_skid) begin
        imm_p1 <= skid_imm;
        tgt_p1 <= skid_tgt;
        ill_p1 <= skid_ill;
      end else if (load_main) begin
        imm_p1 <= imm_p0;
        tgt_p1 <= tgt_p0;
        ill_p1 <= ill_p0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_imm <= imm_p0;
      skid_tgt <= tgt_p0;
      skid_ill <= ill_p0;
    end
  end

  assign in_ready    = !skid_vld;
  assign out_valid   = vld_p1;
  assign out_imm     = imm_p1;
  assign out_target  = tgt_p1;
  assign out_illegal = ill_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share
// all stimulus except the pc, and are checked against hand-computed values.
module tb_imm_gen_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic        out_ready;

  logic [31:0] pc32;
  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32, tgt32;

  logic [63:0] pc64;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64, tgt64;

  int n_cmp = 0;
  int n_bad = 0;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(pc32), .in_imm_src(in_imm_src),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(imm32), .out_target(tgt32), .out_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(pc64), .in_imm_src(in_imm_src),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(imm64), .out_target(tgt64), .out_illegal(ill64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one word at the current time, then sample 1 ns after the next edge.
  task automatic push(input logic [31:0] instr, input logic [2:0] src);
    in_valid   = 1'b1;
    in_instr   = instr;
    in_imm_src = src;
    @(posedge clk);
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    in_imm_src = '0; out_ready = 1'b1;
    pc32 = 32'h0000_1000; pc64 = 64'h0000_0000_0000_1000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid32, 0);
    check("rst_in_ready",  in_ready32, 1);
    check("rst_imm",       imm32, 0);
    check("rst_target",    tgt32, 0);
    check("rst_illegal",   ill32, 0);
    check("rst_valid64",   out_valid64, 0);
    #4 reset = 1'b0;
    @(posedge clk); #1;

    // Formats, back-to-back with out_ready high.
    push(32'hFFF00093, 3'b000);
    check("I_valid", out_valid32, 1);
    check("I_imm",   imm32, 32'hFFFFFFFF);
    check("I_tgt",   tgt32, 32'h00000FFF);
    check("I_imm64", imm64, 64'hFFFFFFFF_FFFFFFFF);
    push(32'hFE20AE23, 3'b001);
    check("S_valid", out_valid32, 1);
    check("S_imm",   imm32, 32'hFFFFFFFC);
    check("S_tgt",   tgt32, 32'h00000FFC);
    push(32'hFE000CE3, 3'b010);
    check("B_imm",   imm32, 32'hFFFFFFF8);
    check("B_tgt",   tgt32, 32'h00000FF8);
    push(32'h001000EF, 3'b011);
    check("J_imm",   imm32, 32'h00000800);
    check("J_tgt",   tgt32, 32'h00001800);
    push(32'h123452B7, 3'b100);
    check("U_imm",   imm32, 32'h12345000);
    check("U_tgt",   tgt32, 32'h12346000);
    push(32'h800002B7, 3'b100);
    check("U_neg_imm32", imm32, 32'h80000000);
    check("U_neg_imm64", imm64, 64'hFFFFFFFF_80000000);
    check("U_neg_tgt64", tgt64, 64'hFFFFFFFF_80001000);
    push(32'h03F00013, 3'b101);
    check("shamt_imm32", imm32, 32'h0000001F);
    check("shamt_imm64", imm64, 64'h3F);
    check("shamt_tgt64", tgt64, 64'h103F);
    push(32'h800F8073, 3'b110);
    check("zimm_imm",   imm32, 32'h0000001F);
    check("zimm_imm64", imm64, 64'h1F);
    check("zimm_ill",   ill32, 0);
    push(32'hFFFFFFFF, 3'b111);
    check("ill_flag64", ill64, 1);
    check("ill_imm64",  imm64, 0);
    check("ill_tgt64",  tgt64, 0);
    check("ill_flag32", ill32, 1);
    in_valid = 1'b0;
    edge_wait();
    check("idle_valid", out_valid32, 0);
    check("idle_ill",   ill32, 1);

    // Back-pressure: four U-format words with out_ready low, pc = 0.
    pc32 = '0; pc64 = '0;
    out_ready = 1'b0;
    push(32'h00001037, 3'b100);
    check("bp_A_valid", out_valid32, 1);
    check("bp_A_ready", in_ready32, 1);
    push(32'h00002037, 3'b100);
    check("bp_B_ready", in_ready32, 0);
    check("bp_hold_A",  imm32, 32'h1000);
    push(32'h00003037, 3'b100);
    check("bp_stall_ready", in_ready32, 0);
    check("bp_stall_imm",   imm32, 32'h1000);
    out_ready = 1'b1;
    edge_wait();
    check("bp_drain_B",     imm32, 32'h2000);
    check("bp_recover_rdy", in_ready32, 1);
    edge_wait();
    check("bp_C_imm",   imm32, 32'h3000);
    check("sim_valid",  out_valid32, 1);
    check("sim_ready",  in_ready32, 1);
    push(32'h00004037, 3'b100);
    check("bp_D_imm",   imm32, 32'h4000);
    check("bp_D_tgt",   tgt32, 32'h4000);
    in_valid = 1'b0;
    edge_wait();
    check("bp_empty",   out_valid32, 0);

    // Flush with both entries full and in_valid high.
    out_ready = 1'b0;
    push(32'h00005037, 3'b100);
    push(32'h00006037, 3'b100);
    check("fl_full_ready", in_ready32, 0);
    flush = 1'b1;
    push(32'h00007037, 3'b100);
    check("fl_valid", out_valid32, 0);
    check("fl_ready", in_ready32, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    edge_wait();
    check("fl_nothing", out_valid32, 0);
    // Flush beats a same-cycle accept into an empty block.
    flush = 1'b1;
    push(32'h00008037, 3'b100);
    check("fl_prio_valid", out_valid32, 0);
    flush = 1'b0; in_valid = 1'b0;
    edge_wait();
    check("fl_prio_after", out_valid32, 0);

    // Asynchronous reset between edges.
    out_ready = 1'b0;
    push(32'h00009037, 3'b100);
    push(32'h0000A037, 3'b100);
    check("ar_pre_valid", out_valid32, 1);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("ar_valid",  out_valid32, 0);
    check("ar_ready",  in_ready32, 1);
    check("ar_imm",    imm32, 0);
    check("ar_valid64", out_valid64, 0);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    push(32'h0000B037, 3'b100);
    check("ar_post_valid", out_valid32, 1);
    check("ar_post_imm",   imm32, 32'hB000);
    in_valid = 1'b0;
    edge_wait();
    check("ar_post_empty", out_valid32, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
